// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the inter-stage pipeline registers: control bit map,
// default widths and the main-slot steering encoding.
package pipe_stage_skid_pkg;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMTORG  = 1;
  localparam int unsigned CTRL_JUMP     = 2;
  localparam int unsigned CTRL_MEMWR    = 3;
  localparam int unsigned CTRL_BRANCH   = 4;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    MAIN_HOLD,
    MAIN_LOAD_IN,
    MAIN_LOAD_SKID,
    MAIN_CLEAR
  } main_sel_e;

  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One pipeline entry: valid flag plus control and data bundles. The control
// register is zeroed whenever the entry goes invalid so a bubble never writes back.
module pipe_slot #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 96
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Clear wins over load; data is left untouched on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush and an
// optional skid entry that keeps in_ready free of any path from out_ready.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W = 3 * XLEN,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic              accept;
  logic              deliver;
  main_sel_e         main_sel;
  logic              main_load;
  logic              main_clear;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;

  assign accept  = in_valid & in_ready;
  assign deliver = main_valid & out_ready;

  // Skid always drains into main first, which keeps ordering strictly FIFO.
  always_comb begin
    main_sel = MAIN_HOLD;
    if (flush) begin
      main_sel = MAIN_CLEAR;
    end else if (deliver) begin
      if (skid_valid)  main_sel = MAIN_LOAD_SKID;
      else if (accept) main_sel = MAIN_LOAD_IN;
      else             main_sel = MAIN_CLEAR;
    end else if (accept && !main_valid) begin
      main_sel = MAIN_LOAD_IN;
    end
  end

  always_comb begin
    main_load   = (main_sel == MAIN_LOAD_IN) || (main_sel == MAIN_LOAD_SKID);
    main_clear  = (main_sel == MAIN_CLEAR);
    main_d_ctrl = (main_sel == MAIN_LOAD_SKID) ? skid_ctrl : in_ctrl;
    main_d_data = (main_sel == MAIN_LOAD_SKID) ? skid_data : in_data;
  end

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d_ctrl(main_d_ctrl),
    .d_data(main_d_data),
    .valid (main_valid),
    .ctrl  (main_ctrl),
    .data  (main_data)
  );

  generate
    if (SKID != 0) begin : gen_skid
      logic skid_load;
      logic skid_clear;

      assign skid_load  = !flush && accept && main_valid && !deliver;
      assign skid_clear = flush || (deliver && skid_valid);
      assign in_ready   = !skid_valid;

      pipe_slot #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
      ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d_ctrl(in_ctrl),
        .d_data(in_data),
        .valid (skid_valid),
        .ctrl  (skid_ctrl),
        .data  (skid_data)
      );
    end else begin : gen_no_skid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready   = !main_valid || out_ready;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occ       = occ_count(main_valid, skid_valid);

endmodule
